// File: rtl/localbus_crc_engine.sv
// rtl/localbus_crc_engine.sv - multi-channel streaming CRC generator/checker
// One IDLE/ACTIVE accumulator per channel; result and framing errors are registered one cycle after the word.
module localbus_crc_engine #(
  parameter int                 DATA_W  = 16,
  parameter int                 CRC_W   = 4,
  parameter logic [CRC_W-1:0]   POLY    = 4'h3,
  parameter logic [CRC_W-1:0]   INIT    = 4'h0,
  parameter logic [CRC_W-1:0]   XOR_OUT = 4'h0,
  parameter int                 CH_N    = 1,
  parameter int                 LEN_W   = 16,
  localparam int                CH_W    = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [DATA_W-1:0] in_data,
  input  logic              chk_en,
  input  logic [CRC_W-1:0]  chk_crc,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [CRC_W-1:0]  res_crc,
  output logic [LEN_W-1:0]  res_len,
  output logic              res_err,
  output logic              proto_err
);

  // Storage is sized to the full index range so any in_ch value selects a real slot.
  localparam int CH_SLOTS = 1 << CH_W;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q [CH_SLOTS];
  logic [CRC_W-1:0]   acc_q   [CH_SLOTS];
  logic [LEN_W-1:0]   len_q   [CH_SLOTS];

  state_t             nxt_state;
  logic [CRC_W-1:0]   nxt_acc;
  logic [LEN_W-1:0]   nxt_len;
  logic               ch_ok;
  logic               wr;
  logic               emit;
  logic               perr;
  logic [CRC_W-1:0]   base_acc;
  logic [LEN_W-1:0]   base_len;
  logic [CRC_W-1:0]   upd_crc;
  logic [LEN_W-1:0]   len_inc;
  logic [CRC_W-1:0]   fin_crc;

  function automatic logic [CRC_W-1:0] crc_upd(input logic [CRC_W-1:0] c_in,
                                               input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      fb = d[b] ^ c[CRC_W-1];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  always_comb begin
    ch_ok     = 32'(in_ch) < CH_N;
    nxt_state = state_q[in_ch];
    nxt_acc   = acc_q[in_ch];
    nxt_len   = len_q[in_ch];
    wr        = 1'b0;
    emit      = 1'b0;
    perr      = 1'b0;
    // A sof always restarts from INIT, discarding whatever frame was open.
    base_acc  = (in_sof || state_q[in_ch] == IDLE) ? INIT : acc_q[in_ch];
    base_len  = in_sof ? '0 : len_q[in_ch];
    upd_crc   = crc_upd(base_acc, in_data);
    len_inc   = (&base_len) ? base_len : base_len + 1'b1;
    fin_crc   = upd_crc ^ XOR_OUT;
    if (in_valid) begin
      if (!ch_ok) begin
        perr = 1'b1;
      end else if (in_sof || state_q[in_ch] == ACTIVE) begin
        wr   = 1'b1;
        perr = in_sof && (state_q[in_ch] == ACTIVE);
        if (in_eof) begin
          emit      = 1'b1;
          nxt_state = IDLE;
          nxt_acc   = INIT;
          nxt_len   = '0;
        end else begin
          nxt_state = ACTIVE;
          nxt_acc   = upd_crc;
          nxt_len   = len_inc;
        end
      end else begin
        perr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_SLOTS; i++) begin
        state_q[i] <= IDLE;
        acc_q[i]   <= INIT;
        len_q[i]   <= '0;
      end
    end else if (wr) begin
      state_q[in_ch] <= nxt_state;
      acc_q[in_ch]   <= nxt_acc;
      len_q[in_ch]   <= nxt_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_crc   <= '0;
      res_len   <= '0;
      res_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      res_valid <= emit;
      proto_err <= perr;
      if (emit) begin
        res_ch  <= in_ch;
        res_crc <= fin_crc;
        res_len <= len_inc;
        res_err <= chk_en && (fin_crc != chk_crc);
      end
    end
  end

endmodule

// File: tb/tb_localbus_crc_engine.sv
// tb/tb_localbus_crc_engine.sv - self-checking bench for localbus_crc_engine
// Two instances (CH_N=1 / CH_N=2 with LEN_W=2) share stimulus; a polynomial-arithmetic model predicts every output.
module tb_localbus_crc_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [0:0]  in_ch = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [15:0] in_data = '0;
  logic        chk_en = 1'b0;
  logic [3:0]  chk_crc = '0;

  logic        a_valid, a_err, a_perr;
  logic [0:0]  a_ch;
  logic [3:0]  a_crc;
  logic [15:0] a_len;
  logic        b_valid, b_err, b_perr;
  logic [0:0]  b_ch;
  logic [3:0]  b_crc;
  logic [1:0]  b_len;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  localbus_crc_engine #(.CH_N(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_sof(in_sof),
    .in_eof(in_eof), .in_data(in_data), .chk_en(chk_en), .chk_crc(chk_crc),
    .res_valid(a_valid), .res_ch(a_ch), .res_crc(a_crc), .res_len(a_len),
    .res_err(a_err), .proto_err(a_perr)
  );

  localbus_crc_engine #(.CH_N(2), .LEN_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_sof(in_sof),
    .in_eof(in_eof), .in_data(in_data), .chk_en(chk_en), .chk_crc(chk_crc),
    .res_valid(b_valid), .res_ch(b_ch), .res_crc(b_crc), .res_len(b_len),
    .res_err(b_err), .proto_err(b_perr)
  );

  // Model: CRC (INIT=0) of a message M is M(x)*x^4 mod P, summed from a table of x^k mod P.
  logic [3:0]  xpow [0:271];
  bit          m_act [2][2];
  int          m_cnt [2][2];
  int          m_len [2][2];
  logic [15:0] m_w   [2][2][16];

  bit         e_valid [2], n_valid [2];
  bit         e_perr  [2], n_perr  [2];
  bit         e_err   [2], n_err   [2];
  int         e_ch    [2], n_ch    [2];
  int         e_len   [2], n_len   [2];
  logic [3:0] e_crc   [2], n_crc   [2];

  function automatic logic [3:0] model_crc(input int i, input int ch);
    logic [3:0] r = 4'h0;
    int n = m_cnt[i][ch];
    for (int j = 0; j < n; j++)
      for (int b = 0; b < 16; b++)
        if (m_w[i][ch][j][b]) r ^= xpow[(n - 1 - j) * 16 + b + 4];
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("a_valid", int'(a_valid), int'(e_valid[0]));
      check("a_perr",  int'(a_perr),  int'(e_perr[0]));
      check("a_ch",    int'(a_ch),    e_ch[0]);
      check("a_crc",   int'(a_crc),   int'(e_crc[0]));
      check("a_len",   int'(a_len),   e_len[0]);
      check("a_err",   int'(a_err),   int'(e_err[0]));
      check("b_valid", int'(b_valid), int'(e_valid[1]));
      check("b_perr",  int'(b_perr),  int'(e_perr[1]));
      check("b_ch",    int'(b_ch),    e_ch[1]);
      check("b_crc",   int'(b_crc),   int'(e_crc[1]));
      check("b_len",   int'(b_len),   e_len[1]);
      check("b_err",   int'(b_err),   int'(e_err[1]));
    end
  end

  task automatic step(input bit rst, input bit v, input int ch, input bit sof, input bit eof,
                      input logic [15:0] d, input bit ce = 1'b0, input logic [3:0] cc = 4'h0);
    int chn, lmax;
    @(negedge clk);
    rst_n = ~rst; in_valid = v; in_ch = 1'(ch); in_sof = sof; in_eof = eof;
    in_data = d; chk_en = ce; chk_crc = cc;
    for (int i = 0; i < 2; i++) begin
      chn  = (i == 0) ? 1 : 2;
      lmax = (i == 0) ? 65535 : 3;
      n_valid[i] = 1'b0; n_perr[i] = 1'b0;
      n_ch[i] = e_ch[i]; n_crc[i] = e_crc[i]; n_len[i] = e_len[i]; n_err[i] = e_err[i];
      if (rst) begin
        for (int c = 0; c < 2; c++) begin m_act[i][c] = 0; m_cnt[i][c] = 0; m_len[i][c] = 0; end
        n_ch[i] = 0; n_crc[i] = 0; n_len[i] = 0; n_err[i] = 0;
      end else if (v) begin
        if (ch >= chn) n_perr[i] = 1'b1;
        else if (!sof && !m_act[i][ch]) n_perr[i] = 1'b1;
        else begin
          if (sof) begin
            if (m_act[i][ch]) n_perr[i] = 1'b1;
            m_cnt[i][ch] = 0; m_len[i][ch] = 0; m_act[i][ch] = 1;
          end
          m_w[i][ch][m_cnt[i][ch]] = d;
          m_cnt[i][ch]++;
          if (m_len[i][ch] < lmax) m_len[i][ch]++;
          if (eof) begin
            n_valid[i] = 1'b1;
            n_ch[i]    = ch;
            n_crc[i]   = model_crc(i, ch);
            n_len[i]   = m_len[i][ch];
            n_err[i]   = ce && (n_crc[i] != cc);
            m_act[i][ch] = 0; m_cnt[i][ch] = 0; m_len[i][ch] = 0;
          end
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      e_valid[i] = n_valid[i]; e_perr[i] = n_perr[i]; e_ch[i] = n_ch[i];
      e_crc[i] = n_crc[i]; e_len[i] = n_len[i]; e_err[i] = n_err[i];
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    xpow[0] = 4'h1;
    for (int k = 1; k < 272; k++)
      xpow[k] = {xpow[k-1][2:0], 1'b0} ^ (xpow[k-1][3] ? 4'h3 : 4'h0);
    for (int i = 0; i < 2; i++) begin
      e_valid[i] = 0; e_perr[i] = 0; e_err[i] = 0; e_ch[i] = 0; e_len[i] = 0; e_crc[i] = 0;
    end

    // Pin the model against hand-computed values.
    m_w[0][0][0] = 16'h0001; m_cnt[0][0] = 1;
    check("pin_0001", int'(model_crc(0, 0)), 3);
    m_w[0][0][0] = 16'h8000;
    check("pin_8000", int'(model_crc(0, 0)), 3);
    m_w[0][0][0] = 16'h0001; m_w[0][0][1] = 16'h0000; m_cnt[0][0] = 2;
    check("pin_0001_0000", int'(model_crc(0, 0)), 6);
    m_w[0][0][0] = 16'h8000;
    check("pin_8000_0000", int'(model_crc(0, 0)), 6);

    step(1, 0, 0, 0, 0, 16'h0);
    chk_on = 1'b1;
    step(1, 1, 0, 1, 1, 16'hFFFF);
    idle();

    step(0, 1, 0, 1, 1, 16'h0001);
    idle();
    check("lit_crc_0001", int'(a_crc), 3);
    check("lit_len_0001", int'(a_len), 1);
    step(0, 1, 0, 1, 1, 16'h8000);
    step(0, 1, 0, 1, 0, 16'h0001);
    step(0, 1, 0, 0, 1, 16'h0000);
    idle();
    check("lit_crc_2w", int'(a_crc), 6);
    check("lit_len_2w", int'(a_len), 2);

    step(0, 1, 0, 1, 0, 16'h0001);
    step(0, 1, 0, 0, 1, 16'h0000, 1, 4'h6);
    step(0, 1, 0, 1, 0, 16'h0001);
    step(0, 1, 0, 0, 1, 16'h0000, 1, 4'h5);
    idle();
    check("lit_err_bad", int'(a_err), 1);
    step(0, 1, 0, 1, 1, 16'hA5C3, 0, 4'h0);
    step(0, 1, 0, 1, 1, 16'h1234, 1, 4'hF);

    step(0, 1, 0, 1, 0, 16'h0001);
    step(0, 1, 1, 1, 1, 16'h8000);
    step(0, 1, 0, 0, 1, 16'h0000);
    idle();
    step(0, 1, 1, 1, 0, 16'hBEEF);
    step(0, 1, 0, 1, 0, 16'h1357);
    step(0, 1, 1, 0, 0, 16'h2468);
    step(0, 1, 0, 0, 1, 16'hFACE);
    step(0, 1, 1, 0, 1, 16'h0F0F, 1, 4'h0);
    idle();

    step(0, 1, 0, 0, 0, 16'h1234);
    step(0, 1, 0, 0, 1, 16'h1234);
    step(0, 1, 0, 1, 0, 16'h0001);
    step(0, 1, 0, 1, 0, 16'h8000);
    step(0, 1, 0, 0, 1, 16'h0000);
    idle();
    check("lit_abort_crc", int'(a_crc), 6);

    step(0, 1, 0, 1, 0, 16'h0001);
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 1, 16'h0000);
    idle();
    step(0, 1, 1, 1, 0, 16'h0001);
    for (int k = 1; k <= 4; k++) step(0, 1, 1, 0, k == 4, 16'(k * 16'h1111));
    for (int k = 1; k <= 5; k++) step(0, 1, 0, k == 1, k == 5, 16'(k));
    idle();
    check("lit_len_sat_b", int'(b_len), 3);
    check("lit_len_a", int'(a_len), 5);
    idle();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
